bram_fp32_accum: RTL and testbench

Single-port 32-bit block RAM with a built-in combinational IEEE-754 single-precision adder. The adder sums the RAM read data with an external operand. It is the storage and accumulate element of the pulse generator: the controller reads a word, adds a pulse-shape sample, and writes the sum back (read-modify-write). The same block, with the adder output unused, serves as the plain pin-event memory.

---
 rtl/bram_fp32_accum.sv | 174 +++++++++++++++++
 tb/tb_bram_fp32_accum.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_fp32_accum.sv
// Single-port 32-bit block RAM with a combinational fp32 adder on the read port.
// The adder sums the registered read word with an external operand so a
// controller can do read / add / write-back accumulation on the same word.
// The arithmetic flushes subnormals to zero and rounds to nearest, ties to even.
module bram_fp32_accum #(
    parameter int DEPTH = 1024,
    parameter int AW    = 32
) (
    input  logic          clka,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          wea,
    input  logic [AW-1:0] addra,
    input  logic [31:0]   dina,
    output logic [31:0]   douta,
    input  logic [31:0]   add_b,
    output logic [31:0]   sum
);
    localparam int          IW   = $clog2(DEPTH);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Power-up contents are zero; reset never touches the array.
    logic [31:0]   mem [DEPTH] = '{default: '0};
    logic [IW-1:0] idx;
    logic          unused_addr_bits;

    // Byte address to word index; upper bits are dropped so the array wraps.
    assign idx              = addra[IW+1:2];
    assign unused_addr_bits = ^{addra[AW-1:IW+2], addra[1:0]};

    // Array write port, no reset so it maps onto block RAM.
    always_ff @(posedge clka) begin
        if (ena && wea) begin
            mem[idx] <= dina;
        end
    end

    // Registered read data; writes leave it unchanged.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            douta <= '0;
        end else if (ena && !wea) begin
            douta <= mem[idx];
        end
    end

    // Operand field decode
    logic       sa, sb;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign {sa, ea, fa} = douta;
    assign {sb, eb, fb} = add_b;
    assign a_nan  = (ea == 8'hFF) && (fa != '0);
    assign b_nan  = (eb == 8'hFF) && (fb != '0);
    assign a_inf  = (ea == 8'hFF) && (fa == '0);
    assign b_inf  = (eb == 8'hFF) && (fb == '0);
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);

    logic              big_s, sml_s;
    logic [7:0]        big_e, sml_e, diff;
    logic [22:0]       big_f, sml_f;
    logic [26:0]       sml_ext, sml_al;
    logic              sticky;
    logic [27:0]       big_ext, raw;
    logic [26:0]       norm;
    logic [4:0]        lz;
    logic              found;
    logic signed [9:0] exp_n;
    logic              rnd_up;
    logic [24:0]       mant_r;
    logic [22:0]       frac_r;

    // Magnitude-ordered align / add / normalise / round, then the special-case mux.
    always_comb begin
        big_s   = sa;
        big_e   = ea;
        big_f   = fa;
        sml_s   = sb;
        sml_e   = eb;
        sml_f   = fb;
        sml_al  = '0;
        sticky  = 1'b0;
        raw     = '0;
        norm    = '0;
        lz      = '0;
        found   = 1'b0;
        exp_n   = '0;
        rnd_up  = 1'b0;
        mant_r  = '0;
        frac_r  = '0;
        sum     = '0;

        // Larger magnitude goes on the big side so subtraction never goes negative.
        if ({eb, fb} > {ea, fa}) begin
            big_s = sb;
            big_e = eb;
            big_f = fb;
            sml_s = sa;
            sml_e = ea;
            sml_f = fa;
        end

        diff    = big_e - sml_e;
        sml_ext = {1'b1, sml_f, 3'b000};
        if (diff >= 8'd27) begin
            sml_al = '0;
            sticky = 1'b1;
        end else begin
            sml_al = sml_ext >> diff;
            sticky = |(sml_ext & ~(27'h7FF_FFFF << diff));
        end
        sml_al[0] = sml_al[0] | sticky;

        big_ext = {2'b01, big_f, 3'b000};
        if (big_s == sml_s) begin
            raw = big_ext + {1'b0, sml_al};
        end else begin
            raw = big_ext - {1'b0, sml_al};
        end

        exp_n = $signed({2'b00, big_e});
        if (raw[27]) begin
            norm  = {raw[27:2], raw[1] | raw[0]};
            exp_n = exp_n + 10'sd1;
        end else begin
            for (int i = 26; i >= 0; i--) begin
                if (!found && raw[i]) begin
                    lz    = 5'(26 - i);
                    found = 1'b1;
                end
            end
            norm  = raw[26:0] << lz;
            exp_n = exp_n - $signed({5'b00000, lz});
        end

        // Guard, round, sticky sit in norm[2:0]; norm[3] is the kept lsb.
        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r = {1'b0, norm[26:3]} + {24'd0, rnd_up};
        if (mant_r[24]) begin
            exp_n  = exp_n + 10'sd1;
            frac_r = mant_r[23:1];
        end else begin
            frac_r = mant_r[22:0];
        end

        if (a_nan || b_nan) begin
            sum = QNAN;
        end else if (a_inf && b_inf) begin
            sum = (sa != sb) ? QNAN : {sa, 8'hFF, 23'd0};
        end else if (a_inf) begin
            sum = {sa, 8'hFF, 23'd0};
        end else if (b_inf) begin
            sum = {sb, 8'hFF, 23'd0};
        end else if (a_zero && b_zero) begin
            sum = {sa & sb, 31'd0};
        end else if (a_zero) begin
            sum = {sb, eb, fb};
        end else if (b_zero) begin
            sum = {sa, ea, fa};
        end else if (raw == '0) begin
            sum = '0;
        end else if (exp_n >= 10'sd255) begin
            sum = {big_s, 8'hFF, 23'd0};
        end else if (exp_n <= 10'sd0) begin
            sum = '0;
        end else begin
            sum = {big_s, exp_n[7:0], frac_r};
        end
    end

endmodule

// File: tb/tb_bram_fp32_accum.sv
// Bench for bram_fp32_accum: directed memory/adder scenarios plus randomized
// traffic checked against an array memory model and a real-arithmetic fp32 model.
module tb_bram_fp32_accum;
    logic        clka;
    logic        rst_n;
    logic        ena;
    logic        wea;
    logic [31:0] addra;
    logic [31:0] dina;
    logic [31:0] douta;
    logic [31:0] add_b;
    logic [31:0] sum;

    int vectors;
    int miscompares;

    logic [31:0] ref_mem [1024];
    logic [31:0] ref_dout;

    bram_fp32_accum #(.DEPTH(1024), .AW(32)) dut (
        .clka  (clka),
        .rst_n (rst_n),
        .ena   (ena),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .douta (douta),
        .add_b (add_b),
        .sum   (sum)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int widx(logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    function automatic real fp32_to_real(logic [31:0] x);
        logic [63:0] bits;
        if (x[30:23] == 8'd0) return 0.0;
        bits = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
        return $bitstoreal(bits);
    endfunction

    // Round a real to fp32 (nearest-even), flushing tiny results to +0.
    function automatic logic [31:0] real_to_fp32(real r);
        logic [63:0] bits;
        logic [52:0] m;
        logic [24:0] keep;
        logic        s, g, st;
        int          e;
        if (r == 0.0) return 32'h0000_0000;
        bits = $realtobits(r);
        s    = bits[63];
        e    = int'(bits[62:52]) - 1023 + 127;
        m    = {1'b1, bits[51:0]};
        keep = {1'b0, m[52:29]};
        g    = m[28];
        st   = |m[27:0];
        if (g && (st || keep[0])) keep = keep + 25'd1;
        if (keep[24]) begin
            keep = keep >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return 32'h0000_0000;
        return {s, 8'(e), keep[22:0]};
    endfunction

    function automatic logic [31:0] model_add(logic [31:0] a, logic [31:0] b);
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        if (a_nan || b_nan) return 32'h7FC0_0000;
        if (a_inf && b_inf) return (a[31] != b[31]) ? 32'h7FC0_0000 : a;
        if (a_inf) return a;
        if (b_inf) return b;
        if (a_zero && b_zero) return {a[31] & b[31], 31'd0};
        if (a_zero) return b;
        if (b_zero) return a;
        return real_to_fp32(fp32_to_real(a) + fp32_to_real(b));
    endfunction

    function automatic logic [31:0] rand_fp();
        int         sel;
        logic [7:0] e;
        sel = $urandom_range(0, 19);
        if (sel == 0) begin
            case ($urandom_range(0, 7))
                0: return 32'h0000_0000;
                1: return 32'h8000_0000;
                2: return 32'h7F80_0000;
                3: return 32'hFF80_0000;
                4: return 32'h7FC0_0000;
                5: return 32'h7F80_0001;
                6: return 32'h0000_0123;
                default: return 32'h8040_0000;
            endcase
        end
        if (sel == 1) e = 8'($urandom_range(250, 254));
        else          e = 8'($urandom_range(110, 140));
        return {1'($urandom()), e, 23'($urandom())};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        ena   = 1'b1;
        wea   = 1'b1;
        addra = a;
        dina  = d;
        tick();
        ref_mem[widx(a)] = d;
        ena = 1'b0;
        wea = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        ena   = 1'b1;
        wea   = 1'b0;
        addra = a;
        tick();
        ref_dout = ref_mem[widx(a)];
        ena = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        ena   = 1'b1;
        wea   = 1'b0;
        addra = 32'h004;
        dina  = '0;
        add_b = 32'h3F80_0000;
        repeat (3) tick();
        vectors++;
        if (douta !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_hold douta got %h expected %h", douta, 32'h0);
        end
        vectors++;
        if (sum !== 32'h3F80_0000) begin
            miscompares++;
            $display("FAIL reset_sum got %h expected %h", sum, 32'h3F80_0000);
        end
        #2 rst_n = 1'b1;
        tick();
        ref_dout = ref_mem[1];
        do_write(32'h008, 32'hDEAD_BEEF);
        do_read(32'h008);
        vectors++;
        if (douta !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL reset_preread got %h expected %h", douta, 32'hDEAD_BEEF);
        end
        ena   = 1'b1;
        wea   = 1'b0;
        addra = 32'h008;
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (douta !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_async got %h expected %h", douta, 32'h0);
        end
        tick();
        vectors++;
        if (douta !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_held_edge got %h expected %h", douta, 32'h0);
        end
        #2 rst_n = 1'b1;
        tick();
        ref_dout = ref_mem[2];
        ena = 1'b0;
        vectors++;
        if (douta !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL reset_mem_kept got %h expected %h", douta, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_latency();
        do_write(32'h004, 32'h3F80_0000);
        vectors++;
        if (douta !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL write_nochange got %h expected %h", douta, 32'hDEAD_BEEF);
        end
        ena   = 1'b1;
        wea   = 1'b0;
        addra = 32'h004;
        #1;
        vectors++;
        if (douta !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL read_before_edge got %h expected %h", douta, 32'hDEAD_BEEF);
        end
        tick();
        ref_dout = ref_mem[1];
        vectors++;
        if (douta !== 32'h3F80_0000) begin
            miscompares++;
            $display("FAIL read_latency got %h expected %h", douta, 32'h3F80_0000);
        end
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wea   = 1'($urandom());
            addra = $urandom();
            dina  = $urandom();
            tick();
            vectors++;
            if (douta !== 32'h3F80_0000) begin
                miscompares++;
                $display("FAIL idle_hold cycle %0d got %h expected %h", i, douta, 32'h3F80_0000);
            end
        end
        vectors++;
        if (ref_mem[1] !== 32'h3F80_0000 || ref_mem[2] !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL idle_model got %h expected %h", ref_mem[1], 32'h3F80_0000);
        end
        do_read(32'h008);
        vectors++;
        if (douta !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL idle_no_write got %h expected %h", douta, 32'hDEAD_BEEF);
        end
        do_read(32'h004);
    endtask

    task automatic test_alias();
        do_write(32'h1004, 32'h4000_0000);
        vectors++;
        if (douta !== 32'h3F80_0000) begin
            miscompares++;
            $display("FAIL alias_nochange got %h expected %h", douta, 32'h3F80_0000);
        end
        do_read(32'h004);
        vectors++;
        if (douta !== 32'h4000_0000) begin
            miscompares++;
            $display("FAIL alias_read got %h expected %h", douta, 32'h4000_0000);
        end
        do_write(32'h0000_0007, 32'h1234_5678);
        do_read(32'hABCD_E005);
        vectors++;
        if (douta !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL alias_lowbits got %h expected %h", douta, 32'h1234_5678);
        end
    endtask

    task automatic test_adder_directed();
        logic [31:0] tv [18][3];
        tv = '{
            '{32'h3F80_0000, 32'h3F00_0000, 32'h3FC0_0000},
            '{32'h3FC0_0000, 32'h4020_0000, 32'h4080_0000},
            '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000},
            '{32'h0000_0000, 32'h3DA3_39C1, 32'h3DA3_39C1},
            '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000},
            '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000},
            '{32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000},
            '{32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002},
            '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000},
            '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000},
            '{32'h0040_0000, 32'h0040_0000, 32'h0000_0000},
            '{32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000},
            '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000},
            '{32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000},
            '{32'h0080_0000, 32'h8080_0001, 32'h0000_0000},
            '{32'h3F80_0000, 32'hB380_0000, 32'h3F7F_FFFF},
            '{32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000},
            '{32'h4B80_0000, 32'h4040_0000, 32'h4B80_0002}
        };
        for (int i = 0; i < 18; i++) begin
            do_write(32'h200, tv[i][0]);
            do_read(32'h200);
            add_b = tv[i][1];
            #1;
            vectors++;
            if (douta !== tv[i][0]) begin
                miscompares++;
                $display("FAIL adder_dir_douta %0d got %h expected %h", i, douta, tv[i][0]);
            end
            vectors++;
            if (sum !== tv[i][2]) begin
                miscompares++;
                $display("FAIL adder_dir_sum %0d a=%h b=%h got %h expected %h",
                         i, tv[i][0], tv[i][1], sum, tv[i][2]);
            end
        end
    endtask

    task automatic test_adder_random();
        logic [31:0] a, b, ad;
        for (int i = 0; i < 300; i++) begin
            a  = rand_fp();
            b  = rand_fp();
            if ($urandom_range(0, 3) == 0) b = {~a[31], a[30:8], 8'($urandom())};
            ad = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 1023)) << 2);
            do_write(ad, a);
            do_read(ad);
            add_b = b;
            #1;
            vectors++;
            if (douta !== ref_dout) begin
                miscompares++;
                $display("FAIL adder_rnd_douta %0d got %h expected %h", i, douta, ref_dout);
            end
            vectors++;
            if (sum !== model_add(ref_dout, b)) begin
                miscompares++;
                $display("FAIL adder_rnd_sum %0d a=%h b=%h got %h expected %h",
                         i, ref_dout, b, sum, model_add(ref_dout, b));
            end
            b     = rand_fp();
            add_b = b;
            #1;
            vectors++;
            if (sum !== model_add(ref_dout, b)) begin
                miscompares++;
                $display("FAIL adder_rnd_comb %0d a=%h b=%h got %h expected %h",
                         i, ref_dout, b, sum, model_add(ref_dout, b));
            end
        end
    endtask

    task automatic test_mem_random();
        logic e, w;
        logic [31:0] ad, d;
        for (int i = 0; i < 300; i++) begin
            e  = ($urandom_range(0, 3) != 0);
            w  = 1'($urandom());
            ad = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 7)) << 2);
            d  = $urandom();
            ena   = e;
            wea   = w;
            addra = ad;
            dina  = d;
            tick();
            if (e && !w) ref_dout = ref_mem[widx(ad)];
            if (e && w)  ref_mem[widx(ad)] = d;
            vectors++;
            if (douta !== ref_dout) begin
                miscompares++;
                $display("FAIL mem_rnd %0d ena=%b wea=%b addr=%h got %h expected %h",
                         i, e, w, ad, douta, ref_dout);
            end
        end
        ena = 1'b0;
        wea = 1'b0;
    endtask

    task automatic test_rmw();
        logic [31:0] acc;
        acc = 32'h0;
        do_write(32'h004, 32'h0);
        for (int p = 0; p < 2; p++) begin
            ena   = 1'b1;
            wea   = 1'b0;
            addra = 32'h004;
            tick();
            ena   = 1'b0;
            add_b = 32'h3F59_AD43;
            tick();
            acc = model_add(acc, 32'h3F59_AD43);
            vectors++;
            if (sum !== acc) begin
                miscompares++;
                $display("FAIL rmw_sum pass %0d got %h expected %h", p, sum, acc);
            end
            do_write(32'h004, sum);
        end
        do_read(32'h004);
        vectors++;
        if (douta !== 32'h3FD9_AD43) begin
            miscompares++;
            $display("FAIL rmw_final got %h expected %h", douta, 32'h3FD9_AD43);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ref_dout    = '0;
        foreach (ref_mem[i]) ref_mem[i] = '0;
        rst_n = 1'b0;
        ena   = 1'b0;
        wea   = 1'b0;
        addra = '0;
        dina  = '0;
        add_b = '0;
        test_reset();
        test_latency();
        test_alias();
        test_adder_directed();
        test_adder_random();
        test_mem_random();
        test_rmw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
